// File: rtl/input_arbiter_rr.sv
// Packet round-robin arbiter: per-input FIFOs drained one whole packet at a time onto one bus; 1-cycle read-to-out_wr latency,
// out_rdy low freezes reads and FSM, in_rdy drops at depth-1 occupancy. Define INPUT_ARBITER_PKT_COUNT_EN for the pkt_count output.
module input_arbiter_fifo #(
    parameter int WIDTH      = 72,
    parameter int DEPTH_BITS = 2
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             wr,
    input  logic [WIDTH-1:0] wr_data,
    input  logic             rd,
    output logic [WIDTH-1:0] rd_data,
    output logic             empty,
    output logic             nearly_full
);
    localparam int DEPTH = 2**DEPTH_BITS;
    localparam logic [DEPTH_BITS:0] FULL_CNT = (DEPTH_BITS+1)'(DEPTH);
    localparam logic [DEPTH_BITS:0] NF_CNT   = (DEPTH_BITS+1)'(DEPTH - 1);

    logic [WIDTH-1:0]      mem [DEPTH];
    logic [DEPTH_BITS-1:0] wr_ptr;
    logic [DEPTH_BITS-1:0] rd_ptr;
    logic [DEPTH_BITS:0]   count;
    logic                  full;
    logic                  do_wr;
    logic                  do_rd;

    assign full        = (count == FULL_CNT);
    assign empty       = (count == '0);
    assign nearly_full = (count >= NF_CNT);
    assign do_rd       = rd && !empty;
    // A write into a full FIFO is only taken when a read frees a slot in the same cycle.
    assign do_wr       = wr && (!full || do_rd);
    assign rd_data     = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (do_wr) mem[wr_ptr] <= wr_data;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_wr) wr_ptr <= wr_ptr + 1'b1;
            if (do_rd) rd_ptr <= rd_ptr + 1'b1;
            if (do_wr && !do_rd)      count <= count + 1'b1;
            else if (do_rd && !do_wr) count <= count - 1'b1;
        end
    end
endmodule

module input_arbiter_rr #(
    parameter int DATA_WIDTH      = 64,
    parameter int CTRL_WIDTH      = DATA_WIDTH/8,
    parameter int NUM_QUEUES      = 8,
    parameter int FIFO_DEPTH_BITS = 2
) (
    input  logic                             clk,
    input  logic                             reset,
    input  logic [NUM_QUEUES*DATA_WIDTH-1:0] in_data,
    input  logic [NUM_QUEUES*CTRL_WIDTH-1:0] in_ctrl,
    input  logic [NUM_QUEUES-1:0]            in_wr,
    output logic [NUM_QUEUES-1:0]            in_rdy,
    output logic [DATA_WIDTH-1:0]            out_data,
    output logic [CTRL_WIDTH-1:0]            out_ctrl,
    output logic                             out_wr,
    input  logic                             out_rdy
`ifdef INPUT_ARBITER_PKT_COUNT_EN
    ,
    output logic [31:0]                      pkt_count
`endif
);
    localparam int QW = $clog2(NUM_QUEUES);

    typedef struct packed {
        logic [CTRL_WIDTH-1:0] ctrl;
        logic [DATA_WIDTH-1:0] data;
    } word_t;

    typedef enum logic [1:0] {IDLE, HDRS, PAYLOAD} state_t;

    state_t                state;
    state_t                state_nxt;
    logic [QW-1:0]         rr_ptr;
    logic [QW-1:0]         rr_ptr_nxt;
    logic [QW-1:0]         cur;
    logic [QW-1:0]         cur_nxt;
    logic [NUM_QUEUES-1:0] empty;
    logic [NUM_QUEUES-1:0] nearly_full;
    logic [NUM_QUEUES-1:0] fifo_rd;
    word_t                 head [NUM_QUEUES];
    word_t                 cur_word;
    logic                  rd_en;
    logic                  eop;
    logic                  gnt_vld;
    logic [QW-1:0]         gnt_idx;

    genvar i;
    generate
        for (i = 0; i < NUM_QUEUES; i++) begin : g_q
            word_t wr_word;
            assign wr_word    = {in_ctrl[i*CTRL_WIDTH +: CTRL_WIDTH], in_data[i*DATA_WIDTH +: DATA_WIDTH]};
            assign fifo_rd[i] = rd_en && (cur == QW'(i));

            input_arbiter_fifo #(
                .WIDTH      ($bits(word_t)),
                .DEPTH_BITS (FIFO_DEPTH_BITS)
            ) u_fifo (
                .clk         (clk),
                .reset       (reset),
                .wr          (in_wr[i]),
                .wr_data     (wr_word),
                .rd          (fifo_rd[i]),
                .rd_data     (head[i]),
                .empty       (empty[i]),
                .nearly_full (nearly_full[i])
            );
        end
    endgenerate

    assign in_rdy   = ~nearly_full;
    assign cur_word = head[cur];
    assign rd_en    = (state != IDLE) && out_rdy && !empty[cur];
    assign eop      = (state == PAYLOAD) && rd_en && (cur_word.ctrl != '0);

    // Descending scan so the lowest offset from rr_ptr wins.
    always_comb begin
        gnt_vld = 1'b0;
        gnt_idx = rr_ptr;
        for (int k = NUM_QUEUES-1; k >= 0; k--) begin
            if (!empty[rr_ptr + QW'(k)]) begin
                gnt_vld = 1'b1;
                gnt_idx = rr_ptr + QW'(k);
            end
        end
    end

    always_comb begin
        state_nxt  = state;
        cur_nxt    = cur;
        rr_ptr_nxt = rr_ptr;
        unique case (state)
            IDLE: begin
                if (gnt_vld) begin
                    cur_nxt   = gnt_idx;
                    state_nxt = HDRS;
                end
            end
            HDRS: begin
                if (rd_en && cur_word.ctrl == '0) state_nxt = PAYLOAD;
            end
            PAYLOAD: begin
                if (eop) begin
                    rr_ptr_nxt = cur + 1'b1;
                    state_nxt  = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state    <= IDLE;
            cur      <= '0;
            rr_ptr   <= '0;
            out_wr   <= 1'b0;
            out_data <= '0;
            out_ctrl <= '0;
        end else begin
            state  <= state_nxt;
            cur    <= cur_nxt;
            rr_ptr <= rr_ptr_nxt;
            out_wr <= rd_en;
            if (rd_en) begin
                out_data <= cur_word.data;
                out_ctrl <= cur_word.ctrl;
            end
        end
    end

`ifdef INPUT_ARBITER_PKT_COUNT_EN
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pkt_count <= '0;
        end else if (eop && pkt_count != 32'hFFFF_FFFF) begin
            pkt_count <= pkt_count + 32'd1;
        end
    end
`endif
endmodule
